// File: rtl/resolution_pkg.sv
// resolution_pkg: definitions shared by the resolution detector and the
// downstream aspect-ratio stage.
//   W_BITS_DEF / H_BITS_DEF : default width/height counter widths
//   state_e                 : detector frame-tracking state
//   ASPECT_*                : 20-bit unsigned Q4.16 aspect-ratio format
package resolution_pkg;

  localparam int W_BITS_DEF = 11;
  localparam int H_BITS_DEF = 12;

  typedef enum logic {
    WAIT_VS = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Aspect ratio = width/height as unsigned Q4.16 in 20 bits.
  localparam int                    ASPECT_BITS = 20;
  localparam int                    ASPECT_FRAC = 16;
  localparam logic [ASPECT_BITS-1:0] ASPECT_ONE = 20'h1_0000;

endpackage

// File: rtl/resolution_detector_if.sv
// resolution_detector_if: video timing in, published resolution out.
//   pix_ce, de, vsync           : pixel-qualified timing from the source
//   width, height, locked,
//   res_changed                 : published resolution to the aspect stage
// slave  = detector side, master = source/consumer side.
interface resolution_detector_if
  import resolution_pkg::*;
#(
  parameter int W_BITS = W_BITS_DEF,
  parameter int H_BITS = H_BITS_DEF
);
  logic              pix_ce;
  logic              de;
  logic              vsync;
  logic [W_BITS-1:0] width;
  logic [H_BITS-1:0] height;
  logic              locked;
  logic              res_changed;

  modport slave  (input  pix_ce, de, vsync,
                  output width, height, locked, res_changed);
  modport master (output pix_ce, de, vsync,
                  input  width, height, locked, res_changed);
endinterface

// File: rtl/resolution_detector_sync_edge_det.sv
// sync_edge_det: pix_ce-qualified history of DE/VSYNC and their edges.
//   clk, rst   : clock, synchronous active-high reset
//   ce         : pixel enable; history only advances when ce=1
//   de, vsync  : raw timing inputs
//   de_q       : DE as sampled on the previous pix_ce cycle
//   de_fall    : line close (valid only on ce=1 cycles)
//   vs_rise    : frame boundary (valid only on ce=1 cycles)
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic de,
  input  logic vsync,
  output logic de_q,
  output logic de_fall,
  output logic vs_rise
);
  logic de_d, vs_d, vs_q;

  always_comb begin
    de_d = de_q;
    vs_d = vs_q;
    if (ce) begin
      de_d = de;
      vs_d = vsync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= de_d;
      vs_q <= vs_d;
    end
  end

  assign de_fall = ce & ~de & de_q;
  assign vs_rise = ce & vsync & ~vs_q;
endmodule

// File: rtl/resolution_detector.sv
// resolution_detector: measures active width/height from DE/VSYNC and
// publishes them once STABLE_FRAMES identical good frames have been seen.
//   sysclk, rst : clock, synchronous active-high reset
//   bus (slave) : pix_ce/de/vsync in; width/height/locked/res_changed out
// A frame is closed by the vs_rise that opens the next one, so publishing
// happens on the vs_rise edge ending the STABLE_FRAMES-th matching frame.
module resolution_detector
  import resolution_pkg::*;
#(
  parameter int          STABLE_FRAMES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2**24,
  parameter int          W_BITS         = W_BITS_DEF,
  parameter int          H_BITS         = H_BITS_DEF
) (
  input logic                   sysclk,
  input logic                   rst,
  resolution_detector_if.slave  bus
);
  localparam int M_BITS = $clog2(STABLE_FRAMES + 1);
  localparam int T_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W_BITS-1:0] W_MAX  = '1;
  localparam logic [H_BITS-1:0] H_MAX  = '1;
  localparam logic [M_BITS-1:0] M_TGT  = M_BITS'(STABLE_FRAMES);
  localparam logic [T_BITS-1:0] T_LAST = T_BITS'(TIMEOUT_CYCLES - 1);

  logic de_q, de_fall, vs_rise;

  sync_edge_det u_edge (
    .clk     (sysclk),
    .rst     (rst),
    .ce      (bus.pix_ce),
    .de      (bus.de),
    .vsync   (bus.vsync),
    .de_q    (de_q),
    .de_fall (de_fall),
    .vs_rise (vs_rise)
  );

  state_e            state_q, state_d;
  logic [W_BITS-1:0] pix_cnt_q, pix_cnt_d, ref_w_q, ref_w_d;
  logic [W_BITS-1:0] cand_w_q, cand_w_d, width_q, width_d;
  logic [H_BITS-1:0] line_cnt_q, line_cnt_d, cand_h_q, cand_h_d;
  logic [H_BITS-1:0] height_q, height_d;
  logic [M_BITS-1:0] match_cnt_q, match_cnt_d;
  logic [T_BITS-1:0] to_cnt_q, to_cnt_d;
  logic              frame_bad_q, frame_bad_d, locked_q, locked_d;
  logic              res_changed_q, res_changed_d;
  logic              frame_good, timeout;

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    ref_w_d       = ref_w_q;
    line_cnt_d    = line_cnt_q;
    frame_bad_d   = frame_bad_q;
    cand_w_d      = cand_w_q;
    cand_h_d      = cand_h_q;
    match_cnt_d   = match_cnt_q;
    width_d       = width_q;
    height_d      = height_q;
    locked_d      = locked_q;
    res_changed_d = 1'b0;
    frame_good    = 1'b0;

    // Sticky at T_LAST: the timeout action simply repeats until a vs_rise.
    timeout  = !vs_rise && (to_cnt_q == T_LAST);
    to_cnt_d = vs_rise ? '0 : (timeout ? to_cnt_q : to_cnt_q + 1'b1);

    case (state_q)
      WAIT_VS: begin
        if (vs_rise) begin
          pix_cnt_d   = '0;
          ref_w_d     = '0;
          line_cnt_d  = '0;
          frame_bad_d = 1'b0;
          state_d     = MEASURE;
        end
      end
      MEASURE: begin
        if (bus.pix_ce && bus.de) begin
          if (pix_cnt_q != W_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_d == W_MAX) frame_bad_d = 1'b1;
        end
        // Line close is folded in before frame close so a line ending on
        // the vs_rise cycle still counts toward the closing frame.
        if (de_fall) begin
          if (line_cnt_q == '0)          ref_w_d     = pix_cnt_q;
          else if (pix_cnt_q != ref_w_q) frame_bad_d = 1'b1;
          if (line_cnt_q != H_MAX) line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_d == H_MAX) frame_bad_d = 1'b1;
          pix_cnt_d = '0;
        end
        if (vs_rise) begin
          frame_good = !frame_bad_d && (line_cnt_d != '0) && !(de_q && !de_fall);
          if (frame_good) begin
            if (ref_w_d == cand_w_q && line_cnt_d == cand_h_q) begin
              if (match_cnt_q != M_TGT) match_cnt_d = match_cnt_q + 1'b1;
            end else begin
              cand_w_d    = ref_w_d;
              cand_h_d    = line_cnt_d;
              match_cnt_d = M_BITS'(1);
            end
            if (match_cnt_d == M_TGT) begin
              locked_d = 1'b1;
              if (cand_w_d != width_q || cand_h_d != height_q) begin
                width_d       = cand_w_d;
                height_d      = cand_h_d;
                res_changed_d = 1'b1;
              end
            end else if (ref_w_d != width_q || line_cnt_d != height_q) begin
              locked_d = 1'b0;
            end
          end else begin
            match_cnt_d = '0;
            locked_d    = 1'b0;
          end
          pix_cnt_d   = '0;
          ref_w_d     = '0;
          line_cnt_d  = '0;
          frame_bad_d = 1'b0;
        end
      end
      default: state_d = WAIT_VS;
    endcase

    if (timeout) begin
      locked_d    = 1'b0;
      match_cnt_d = '0;
      state_d     = WAIT_VS;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q       <= WAIT_VS;
      pix_cnt_q     <= '0;
      ref_w_q       <= '0;
      line_cnt_q    <= '0;
      frame_bad_q   <= 1'b0;
      cand_w_q      <= '0;
      cand_h_q      <= '0;
      match_cnt_q   <= '0;
      width_q       <= '0;
      height_q      <= '0;
      locked_q      <= 1'b0;
      res_changed_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      ref_w_q       <= ref_w_d;
      line_cnt_q    <= line_cnt_d;
      frame_bad_q   <= frame_bad_d;
      cand_w_q      <= cand_w_d;
      cand_h_q      <= cand_h_d;
      match_cnt_q   <= match_cnt_d;
      width_q       <= width_d;
      height_q      <= height_d;
      locked_q      <= locked_d;
      res_changed_q <= res_changed_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign bus.width       = width_q;
  assign bus.height      = height_q;
  assign bus.locked      = locked_q;
  // Gated so a pulse registered just before rst rises never shows under rst.
  assign bus.res_changed = res_changed_q & ~rst;
endmodule

// File: tb/tb_resolution_detector.sv
// Directed bench for resolution_detector. Resolutions are scaled down so
// that frames fit well inside TIMEOUT_CYCLES=1000 sysclk cycles.
// A frame is closed by the vs_rise that opens the following frame.
module tb_resolution_detector;
  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  int   n_tests = 0, n_fail = 0;
  int   ce_div = 1;
  int   rc_cnt = 0, rc_in_rst = 0;

  always #5 sysclk = ~sysclk;

  resolution_detector_if #(.W_BITS(11), .H_BITS(12)) vif ();

  resolution_detector #(
    .STABLE_FRAMES  (3),
    .TIMEOUT_CYCLES (1000),
    .W_BITS         (11),
    .H_BITS         (12)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (vif)
  );

  always @(negedge sysclk) begin
    if (vif.res_changed) rc_cnt++;
    if (rst && vif.res_changed) rc_in_rst++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic ce, input logic d, input logic v);
    vif.pix_ce = ce;
    vif.de     = d;
    vif.vsync  = v;
    @(posedge sysclk);
    #1;
  endtask

  // One pixel slot: ce_div-1 idle cycles carrying inverted junk, then the
  // enabled cycle last so results are visible when the task returns.
  task automatic pix(input logic d, input logic v);
    for (int i = 1; i < ce_div; i++) tick(1'b0, ~d, ~v);
    tick(1'b1, d, v);
  endtask

  task automatic vs_edge();
    pix(1'b0, 1'b1);
  endtask

  // Rest of a frame after its opening vs_rise. Line bad_line has bad_w
  // pixels; tail = blanking slots after the last line (0 = line closes on
  // the next vs_rise slot).
  task automatic frame_body(input int w, input int h, input int bad_line,
                            input int bad_w, input int tail);
    int n;
    pix(1'b0, 1'b1);
    pix(1'b0, 1'b0);
    pix(1'b0, 1'b0);
    for (int l = 0; l < h; l++) begin
      n = (l == bad_line) ? bad_w : w;
      for (int p = 0; p < n; p++) pix(1'b1, 1'b0);
      repeat ((l == h - 1) ? tail : 3) pix(1'b0, 1'b0);
    end
  endtask

  task automatic chk_out(input string tag, input int w, input int h, input int lk);
    chk({tag, ".width"},  32'(vif.width),  w);
    chk({tag, ".height"}, 32'(vif.height), h);
    chk({tag, ".locked"}, 32'(vif.locked), lk);
  endtask

  initial begin
    vif.pix_ce = 1'b0;
    vif.de     = 1'b0;
    vif.vsync  = 1'b0;
    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk_out("reset", 0, 0, 0);
    chk("reset.res_changed", 32'(vif.res_changed), 0);
    rst = 1'b0;

    // A: 16x8 locks when frame 3 closes.
    vs_edge();
    frame_body(16, 8, -1, 0, 3); vs_edge(); chk_out("A.f1", 0, 0, 0);
    frame_body(16, 8, -1, 0, 3); vs_edge(); chk_out("A.f2", 0, 0, 0);
    chk("A.f2.res_changed", 32'(vif.res_changed), 0);
    frame_body(16, 8, -1, 0, 3); vs_edge(); chk_out("A.f3", 16, 8, 1);
    chk("A.f3.res_changed", 32'(vif.res_changed), 1);

    // B: switch to 24x12; lock drops, old values held until republished.
    frame_body(24, 12, -1, 0, 3); vs_edge(); chk_out("B.f1", 16, 8, 0);
    frame_body(24, 12, -1, 0, 3); vs_edge(); chk_out("B.f2", 16, 8, 0);
    frame_body(24, 12, -1, 0, 3); vs_edge(); chk_out("B.f3", 24, 12, 1);
    chk("B.f3.res_changed", 32'(vif.res_changed), 1);

    // C: 20x10 with a 19-pixel line in frame 2 restarts the match count.
    frame_body(20, 10, -1, 0, 3); vs_edge(); chk_out("C.f1", 24, 12, 0);
    frame_body(20, 10,  4, 19, 3); vs_edge(); chk_out("C.bad", 24, 12, 0);
    frame_body(20, 10, -1, 0, 3); vs_edge(); chk_out("C.f3", 24, 12, 0);
    frame_body(20, 10, -1, 0, 3); vs_edge(); chk_out("C.f4", 24, 12, 0);
    frame_body(20, 10, -1, 0, 3); vs_edge(); chk_out("C.f5", 20, 10, 1);
    chk("C.f5.res_changed", 32'(vif.res_changed), 1);

    // D: a line still open at vs_rise makes the frame bad.
    frame_body(20, 10, -1, 0, 3);
    repeat (5) pix(1'b1, 1'b0);
    pix(1'b1, 1'b1);
    chk_out("D.open", 20, 10, 0);
    // The frame after inherits a zero-length first line; not checked.
    frame_body(20, 10, -1, 0, 3); vs_edge();
    frame_body(20, 10, -1, 0, 3); vs_edge(); chk_out("D.m1", 20, 10, 0);
    frame_body(20, 10, -1, 0, 3); vs_edge(); chk_out("D.m2", 20, 10, 0);
    // Last line closes on the same slot as vs_rise: frame must count.
    frame_body(20, 10, -1, 0, 0); vs_edge(); chk_out("D.sameslot", 20, 10, 1);
    chk("D.sameslot.res_changed", 32'(vif.res_changed), 0);

    // E: lock at 32x6, then starve VSYNC.
    frame_body(32, 6, -1, 0, 3); vs_edge();
    frame_body(32, 6, -1, 0, 3); vs_edge();
    frame_body(32, 6, -1, 0, 3); vs_edge(); chk_out("E.lock", 32, 6, 1);
    chk("E.lock.res_changed", 32'(vif.res_changed), 1);
    repeat (999) tick(1'b1, 1'b0, 1'b0);
    chk_out("E.to999", 32, 6, 1);
    tick(1'b1, 1'b0, 1'b0);
    chk_out("E.to1000", 32, 6, 0);
    vs_edge();                                        // reopens measurement
    frame_body(32, 6, -1, 0, 3); vs_edge(); chk_out("E.re1", 32, 6, 0);
    frame_body(32, 6, -1, 0, 3); vs_edge(); chk_out("E.re2", 32, 6, 0);
    frame_body(32, 6, -1, 0, 3); vs_edge(); chk_out("E.re3", 32, 6, 1);
    chk("E.re3.res_changed", 32'(vif.res_changed), 0);

    // F: pix_ce active 1 cycle in 3, junk on disabled cycles.
    ce_div = 3;
    frame_body(12, 5, -1, 0, 3); vs_edge(); chk_out("F.f1", 32, 6, 0);
    frame_body(12, 5, -1, 0, 3); vs_edge(); chk_out("F.f2", 32, 6, 0);
    frame_body(12, 5, -1, 0, 3); vs_edge(); chk_out("F.f3", 12, 5, 1);
    chk("F.f3.res_changed", 32'(vif.res_changed), 1);

    // G: reset in the middle of a locked frame.
    pix(1'b0, 1'b1);
    repeat (2) begin
      repeat (12) pix(1'b1, 1'b0);
      repeat (3) pix(1'b0, 1'b0);
    end
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk_out("G.rst", 0, 0, 0);
    chk("G.rst.res_changed", 32'(vif.res_changed), 0);
    rst = 1'b0;
    repeat (3) begin
      repeat (12) pix(1'b1, 1'b0);
      repeat (3) pix(1'b0, 1'b0);
    end
    vs_edge(); chk_out("G.partial", 0, 0, 0);
    frame_body(12, 5, -1, 0, 3); vs_edge(); chk_out("G.f1", 0, 0, 0);

    chk("res_changed.total", 32'(rc_cnt), 5);
    chk("res_changed.in_rst", 32'(rc_in_rst), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
